// File: rtl/mem_initiator_if.sv
// Bundle of request, response and memory-side signals for the load/store initiator.
// The initiator uses the master view; the core/memory environment uses the slave view.
interface mem_initiator_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_error;
  logic        mem_write_enable;
  logic [31:0] mem_address;
  logic [31:0] mem_data_out;
  logic [31:0] mem_data_in;

  modport master (
    input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, mem_data_in,
    output req_ready, resp_valid, resp_rdata, resp_error,
    output mem_write_enable, mem_address, mem_data_out
  );

  modport slave (
    output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, mem_data_in,
    input  req_ready, resp_valid, resp_rdata, resp_error,
    input  mem_write_enable, mem_address, mem_data_out
  );
endinterface

// File: rtl/mem_initiator.sv
// Load/store initiator for a word-only synchronous memory: lane extraction for loads,
// read-modify-write for sub-word stores, and rejection of misaligned accesses.
module mem_initiator #(
  parameter int MEM_READ_LATENCY = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  mem_initiator_if.master bus
);

  localparam int CW = $clog2(MEM_READ_LATENCY + 1) + 1;
  localparam logic [CW-1:0] READ_LAST = CW'(MEM_READ_LATENCY);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    READ  = 2'b01,
    WRITE = 2'b10,
    RESP  = 2'b11
  } state_t;

  state_t        state_r;
  state_t        state_s;
  logic [CW-1:0] cnt_r;
  logic [CW-1:0] cnt_s;
  logic          write_r;
  logic [1:0]    size_r;
  logic          uns_r;
  logic [31:0]   addr_r;
  logic [15:0]   wdata_r;

  logic          resp_valid_r;
  logic          resp_valid_s;
  logic          resp_error_r;
  logic          resp_error_s;
  logic [31:0]   resp_rdata_r;
  logic [31:0]   resp_rdata_s;
  logic          mem_we_r;
  logic          mem_we_s;
  logic [31:0]   mem_addr_r;
  logic [31:0]   mem_addr_s;
  logic [31:0]   mem_wdata_r;
  logic [31:0]   mem_wdata_s;

  logic          accept_s;
  logic          misaligned_s;

  // Little-endian lane select followed by sign or zero extension.
  function automatic logic [31:0] extract_load(input logic [31:0] word, input logic [1:0] size,
                                               input logic uns, input logic [1:0] lo);
    logic [31:0] sh;
    logic [31:0] res;
    sh  = 32'h0000_0000;
    res = 32'h0000_0000;
    case (size)
      2'b00: begin
        sh  = word >> {lo, 3'b000};
        res = {{24{~uns & sh[7]}}, sh[7:0]};
      end
      2'b01: begin
        sh  = word >> {lo[1], 4'b0000};
        res = {{16{~uns & sh[15]}}, sh[15:0]};
      end
      2'b10:   res = word;
      default: res = 32'h0000_0000;
    endcase
    return res;
  endfunction

  // Replace only the addressed lane of the fetched word with the new store data.
  function automatic logic [31:0] merge_store(input logic [31:0] word, input logic [15:0] wd,
                                              input logic [1:0] size, input logic [1:0] lo);
    logic [31:0] mask;
    logic [31:0] ins;
    case (size)
      2'b00: begin
        mask = 32'h0000_00FF << {lo, 3'b000};
        ins  = {24'h00_0000, wd[7:0]} << {lo, 3'b000};
      end
      2'b01: begin
        mask = 32'h0000_FFFF << {lo[1], 4'b0000};
        ins  = {16'h0000, wd} << {lo[1], 4'b0000};
      end
      default: begin
        mask = 32'h0000_0000;
        ins  = 32'h0000_0000;
      end
    endcase
    return (word & ~mask) | ins;
  endfunction

  // Accept qualification and alignment check on the incoming request.
  always_comb begin
    accept_s     = 1'b0;
    misaligned_s = 1'b0;
    if (state_r == IDLE) begin
      accept_s = bus.req_valid;
    end else begin
      accept_s = 1'b0;
    end
    case (bus.req_size)
      2'b00:   misaligned_s = 1'b0;
      2'b01:   misaligned_s = bus.req_addr[0];
      2'b10:   misaligned_s = |bus.req_addr[1:0];
      default: misaligned_s = 1'b1;
    endcase
  end

  // Next-state logic and READ-phase cycle counter.
  always_comb begin
    state_s = state_r;
    cnt_s   = {CW{1'b0}};
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          if (misaligned_s) begin
            state_s = RESP;
          end else if (bus.req_write && (bus.req_size == 2'b10)) begin
            state_s = WRITE;
          end else begin
            state_s = READ;
          end
        end else begin
          state_s = IDLE;
        end
      end
      READ: begin
        if (cnt_r == READ_LAST) begin
          state_s = write_r ? WRITE : RESP;
        end else begin
          state_s = READ;
          cnt_s   = cnt_r + {{(CW-1){1'b0}}, 1'b1};
        end
      end
      WRITE:   state_s = RESP;
      RESP:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Values the registered outputs take on the coming edge, keyed on the transition.
  always_comb begin
    resp_valid_s = (state_s == RESP);
    resp_error_s = (state_r == IDLE) && (state_s == RESP);
    resp_rdata_s = 32'h0000_0000;
    mem_we_s     = (state_s == WRITE);
    mem_addr_s   = 32'h0000_0000;
    mem_wdata_s  = 32'h0000_0000;
    if ((state_r == READ) && (state_s == RESP)) begin
      resp_rdata_s = extract_load(bus.mem_data_in, size_r, uns_r, addr_r[1:0]);
    end else begin
      resp_rdata_s = 32'h0000_0000;
    end
    if ((state_s == READ) || (state_s == WRITE)) begin
      mem_addr_s = (state_r == IDLE) ? {bus.req_addr[31:2], 2'b00} : {addr_r[31:2], 2'b00};
    end else begin
      mem_addr_s = 32'h0000_0000;
    end
    if ((state_r == IDLE) && (state_s == WRITE)) begin
      mem_wdata_s = bus.req_wdata;
    end else if ((state_r == READ) && (state_s == WRITE)) begin
      mem_wdata_s = merge_store(bus.mem_data_in, wdata_r, size_r, addr_r[1:0]);
    end else begin
      mem_wdata_s = 32'h0000_0000;
    end
  end

  // State, latched request and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      cnt_r        <= {CW{1'b0}};
      write_r      <= 1'b0;
      size_r       <= 2'b00;
      uns_r        <= 1'b0;
      addr_r       <= 32'h0000_0000;
      wdata_r      <= 16'h0000;
      resp_valid_r <= 1'b0;
      resp_error_r <= 1'b0;
      resp_rdata_r <= 32'h0000_0000;
      mem_we_r     <= 1'b0;
      mem_addr_r   <= 32'h0000_0000;
      mem_wdata_r  <= 32'h0000_0000;
    end else begin
      state_r      <= state_s;
      cnt_r        <= cnt_s;
      resp_valid_r <= resp_valid_s;
      resp_error_r <= resp_error_s;
      resp_rdata_r <= resp_rdata_s;
      mem_we_r     <= mem_we_s;
      mem_addr_r   <= mem_addr_s;
      mem_wdata_r  <= mem_wdata_s;
      if (accept_s) begin
        write_r <= bus.req_write;
        size_r  <= bus.req_size;
        uns_r   <= bus.req_unsigned;
        addr_r  <= bus.req_addr;
        wdata_r <= bus.req_wdata[15:0];
      end
    end
  end

  // rst_n gating keeps ready low and blocks any write strobe while reset is held.
  assign bus.req_ready        = (state_r == IDLE) && rst_n;
  assign bus.mem_write_enable = mem_we_r && rst_n;
  assign bus.mem_address      = mem_addr_r;
  assign bus.mem_data_out     = mem_wdata_r;
  assign bus.resp_valid       = resp_valid_r;
  assign bus.resp_error       = resp_error_r;
  assign bus.resp_rdata       = resp_rdata_r;

endmodule

// File: tb/tb_mem_initiator.sv
// Bench for mem_initiator: two instances (read latency 1 and 3) on behavioural memories,
// checked against a byte-addressed reference memory.
module tb_mem_initiator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid0;
  logic        req_valid1;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_initiator_if bus0();
  mem_initiator_if bus1();

  assign bus0.req_valid    = req_valid0;
  assign bus1.req_valid    = req_valid1;
  assign bus0.req_write    = req_write;
  assign bus1.req_write    = req_write;
  assign bus0.req_size     = req_size;
  assign bus1.req_size     = req_size;
  assign bus0.req_unsigned = req_unsigned;
  assign bus1.req_unsigned = req_unsigned;
  assign bus0.req_addr     = req_addr;
  assign bus1.req_addr     = req_addr;
  assign bus0.req_wdata    = req_wdata;
  assign bus1.req_wdata    = req_wdata;

  mem_initiator #(.MEM_READ_LATENCY(1)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  mem_initiator #(.MEM_READ_LATENCY(3)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  // Word memories with a read pipeline of the instance's latency
  bit [31:0] mem0 [64];
  bit [31:0] mem1 [64];
  bit [31:0] pipe0;
  bit [31:0] pipe1 [3];

  always @(posedge clk) begin
    if (bus0.mem_write_enable) mem0[bus0.mem_address[7:2]] <= bus0.mem_data_out;
    if (bus1.mem_write_enable) mem1[bus1.mem_address[7:2]] <= bus1.mem_data_out;
    pipe0    <= mem0[bus0.mem_address[7:2]];
    pipe1[0] <= mem1[bus1.mem_address[7:2]];
    pipe1[1] <= pipe1[0];
    pipe1[2] <= pipe1[1];
  end

  assign bus0.mem_data_in = pipe0;
  assign bus1.mem_data_in = pipe1[2];

  int          we_cnt0 = 0;
  int          we_cnt1 = 0;
  int          rv_cnt0 = 0;
  int          nz_cnt0 = 0;
  int          nz_cnt1 = 0;
  int          unal_cnt = 0;
  logic [31:0] waddr0 = 32'h0;
  logic [31:0] waddr1 = 32'h0;

  always @(negedge clk) begin
    if (bus0.mem_write_enable) begin
      we_cnt0 <= we_cnt0 + 1;
      waddr0  <= bus0.mem_address;
    end
    if (bus1.mem_write_enable) begin
      we_cnt1 <= we_cnt1 + 1;
      waddr1  <= bus1.mem_address;
    end
    if (bus0.resp_valid) rv_cnt0 <= rv_cnt0 + 1;
    if (bus0.mem_address != 32'h0) nz_cnt0 <= nz_cnt0 + 1;
    if (bus1.mem_address != 32'h0) nz_cnt1 <= nz_cnt1 + 1;
    if ((bus0.mem_address[1:0] != 2'b00) || (bus1.mem_address[1:0] != 2'b00)) unal_cnt <= unal_cnt + 1;
  end

  // Reference: byte-addressed memory (low 8 address bits, aliasing like the word memory)
  bit [7:0] ref_mem [2][256];

  logic [31:0] ext_addr [5] = '{32'h41, 32'h41, 32'h42, 32'h42, 32'h40};
  logic [1:0]  ext_size [5] = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b00};
  logic        ext_uns  [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
  logic [31:0] ext_want [5] = '{32'hFFFF_FFA5, 32'h0000_00A5, 32'hFFFF_DEAD, 32'h0000_DEAD, 32'hFFFF_FFEF};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, want);
    end
  endtask

  function automatic logic [31:0] ref_word(input int sel, input logic [31:0] a);
    logic [7:0] b;
    b = {a[7:2], 2'b00};
    return {ref_mem[sel][b + 8'd3], ref_mem[sel][b + 8'd2], ref_mem[sel][b + 8'd1], ref_mem[sel][b]};
  endfunction

  function automatic logic [31:0] ref_load(input int sel, input logic [1:0] sz, input logic uns,
                                           input logic [31:0] a);
    logic [7:0]  b;
    logic [15:0] h;
    b = a[7:0];
    h = {ref_mem[sel][b + 8'd1], ref_mem[sel][b]};
    if (sz == 2'b00) return uns ? {24'h0, ref_mem[sel][b]} : {{24{ref_mem[sel][b][7]}}, ref_mem[sel][b]};
    if (sz == 2'b01) return uns ? {16'h0, h} : {{16{h[15]}}, h};
    return ref_word(sel, a);
  endfunction

  task automatic ref_store(input int sel, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
    int n;
    n = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    for (int i = 0; i < n; i++) ref_mem[sel][a[7:0] + 8'(i)] = wd[8*i +: 8];
  endtask

  function automatic logic [31:0] mem_word(input int sel, input logic [31:0] a);
    return (sel == 0) ? mem0[a[7:2]] : mem1[a[7:2]];
  endfunction

  function automatic logic o_ready(input int sel); return (sel == 0) ? bus0.req_ready : bus1.req_ready; endfunction
  function automatic logic o_rv(input int sel); return (sel == 0) ? bus0.resp_valid : bus1.resp_valid; endfunction
  function automatic logic o_re(input int sel); return (sel == 0) ? bus0.resp_error : bus1.resp_error; endfunction
  function automatic logic [31:0] o_rd(input int sel); return (sel == 0) ? bus0.resp_rdata : bus1.resp_rdata; endfunction
  function automatic logic o_we(input int sel); return (sel == 0) ? bus0.mem_write_enable : bus1.mem_write_enable; endfunction
  function automatic logic [31:0] o_ma(input int sel); return (sel == 0) ? bus0.mem_address : bus1.mem_address; endfunction
  function automatic logic [31:0] o_md(input int sel); return (sel == 0) ? bus0.mem_data_out : bus1.mem_data_out; endfunction

  task automatic chk_quiet(input int sel, input logic ready_want);
    chk("rst_ready", 32'(o_ready(sel)), 32'(ready_want));
    chk("rst_resp_valid", 32'(o_rv(sel)), 32'h0);
    chk("rst_resp_error", 32'(o_re(sel)), 32'h0);
    chk("rst_resp_rdata", o_rd(sel), 32'h0);
    chk("rst_mem_we", 32'(o_we(sel)), 32'h0);
    chk("rst_mem_address", o_ma(sel), 32'h0);
    chk("rst_mem_data_out", o_md(sel), 32'h0);
  endtask

  task automatic do_req(input int sel, input logic wr, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] wd, output logic [31:0] got);
    int          lat;
    int          lat_want;
    int          lmem;
    int          we_before;
    int          nz_before;
    logic        err;
    logic [31:0] rd_want;
    lmem     = (sel == 0) ? 1 : 3;
    err      = (sz == 2'b11) || ((sz == 2'b01) && a[0]) || ((sz == 2'b10) && (a[1:0] != 2'b00));
    rd_want  = (!err && !wr) ? ref_load(sel, sz, uns, a) : 32'h0;
    lat_want = err ? 1 : !wr ? lmem + 2 : (sz == 2'b10) ? 2 : lmem + 3;
    @(negedge clk);
    we_before    = (sel == 0) ? we_cnt0 : we_cnt1;
    nz_before    = (sel == 0) ? nz_cnt0 : nz_cnt1;
    req_write    = wr;
    req_size     = sz;
    req_unsigned = uns;
    req_addr     = a;
    req_wdata    = wd;
    if (sel == 0) req_valid0 = 1'b1;
    else          req_valid1 = 1'b1;
    chk("req_ready", 32'(o_ready(sel)), 32'h1);
    @(posedge clk);
    #1;
    req_valid0 = 1'b0;
    req_valid1 = 1'b0;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (o_rv(sel)) begin
        lat = k;
        break;
      end
    end
    got = o_rd(sel);
    chk("latency", 32'(lat), 32'(lat_want));
    chk("resp_error", 32'(o_re(sel)), 32'(err));
    chk("resp_rdata", got, rd_want);
    #1;
    if (!err && wr) begin
      ref_store(sel, sz, a, wd);
      chk("write_count", 32'(((sel == 0) ? we_cnt0 : we_cnt1) - we_before), 32'h1);
      chk("write_addr", (sel == 0) ? waddr0 : waddr1, {a[31:2], 2'b00});
      chk("mem_word", mem_word(sel, a), ref_word(sel, a));
    end else begin
      chk("no_write", 32'(((sel == 0) ? we_cnt0 : we_cnt1) - we_before), 32'h0);
    end
    if (err) chk("err_addr_quiet", 32'(((sel == 0) ? nz_cnt0 : nz_cnt1) - nz_before), 32'h0);
  endtask

  initial begin
    logic [31:0] got;
    logic [1:0]  sz;
    logic [31:0] a;
    int          we_before;
    int          rv_before;

    rst_n        = 1'b0;
    req_valid0   = 1'b1;
    req_valid1   = 1'b1;
    req_write    = 1'b1;
    req_size     = 2'b10;
    req_unsigned = 1'b0;
    req_addr     = 32'h40;
    req_wdata    = 32'h1111_2222;

    // Reset held with a request pending: nothing accepted, everything quiet
    repeat (3) begin
      @(negedge clk);
      chk_quiet(0, 1'b0);
      chk_quiet(1, 1'b0);
    end
    req_valid0 = 1'b0;
    req_valid1 = 1'b0;
    rst_n      = 1'b1;
    #1;
    chk("ready_after_release0", 32'(o_ready(0)), 32'h1);
    chk("ready_after_release1", 32'(o_ready(1)), 32'h1);
    @(negedge clk);
    chk_quiet(0, 1'b1);

    // Latency 1: SW, SB read-modify-write, LW
    do_req(0, 1'b1, 2'b10, 1'b0, 32'h40, 32'hDEAD_BEEF, got);
    chk("sw_mem", mem_word(0, 32'h40), 32'hDEAD_BEEF);
    do_req(0, 1'b1, 2'b00, 1'b0, 32'h41, 32'h1234_56A5, got);
    chk("sb_mem", mem_word(0, 32'h40), 32'hDEAD_A5EF);
    do_req(0, 1'b0, 2'b10, 1'b0, 32'h40, 32'h0, got);
    chk("lw_value", got, 32'hDEAD_A5EF);

    for (int i = 0; i < 5; i++) begin
      do_req(0, 1'b0, ext_size[i], ext_uns[i], ext_addr[i], 32'h0, got);
      chk("extract", got, ext_want[i]);
    end

    // Misaligned and illegal-size requests
    do_req(0, 1'b0, 2'b10, 1'b0, 32'h42, 32'h0, got);
    do_req(0, 1'b1, 2'b01, 1'b0, 32'h43, 32'hCAFE_F00D, got);
    do_req(0, 1'b0, 2'b11, 1'b0, 32'h40, 32'h0, got);
    chk("misaligned_mem_kept", mem_word(0, 32'h40), 32'hDEAD_A5EF);

    // Reset during the READ phase of a byte store
    @(negedge clk);
    we_before    = we_cnt0;
    rv_before    = rv_cnt0;
    req_write    = 1'b1;
    req_size     = 2'b00;
    req_unsigned = 1'b0;
    req_addr     = 32'h44;
    req_wdata    = 32'h0000_00FF;
    req_valid0   = 1'b1;
    @(posedge clk);
    #1;
    req_valid0 = 1'b0;
    @(negedge clk);
    chk("midop_read_addr", bus0.mem_address, 32'h44);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    #1;
    chk("midop_no_write", 32'(we_cnt0 - we_before), 32'h0);
    chk("midop_no_resp", 32'(rv_cnt0 - rv_before), 32'h0);
    chk("midop_ready", 32'(o_ready(0)), 32'h1);
    chk("midop_mem_kept", mem_word(0, 32'h44), ref_word(0, 32'h44));

    // Latency 3: same sequence
    do_req(1, 1'b1, 2'b10, 1'b0, 32'h40, 32'hDEAD_BEEF, got);
    do_req(1, 1'b1, 2'b00, 1'b0, 32'h41, 32'h1234_56A5, got);
    do_req(1, 1'b0, 2'b10, 1'b0, 32'h40, 32'h0, got);
    chk("lw_value_l3", got, 32'hDEAD_A5EF);
    do_req(1, 1'b0, 2'b01, 1'b0, 32'h42, 32'h0, got);
    chk("lh_value_l3", got, 32'hFFFF_DEAD);

    // Randomized traffic on both instances
    for (int sel = 0; sel < 2; sel++) begin
      for (int n = 0; n < 60; n++) begin
        sz = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
        a  = $urandom;
        if ((sz == 2'b01) && ($urandom_range(0, 3) != 0)) a[0] = 1'b0;
        if ((sz == 2'b10) && ($urandom_range(0, 3) != 0)) a[1:0] = 2'b00;
        do_req(sel, 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom, got);
      end
    end

    chk("mem_address_word_aligned", 32'(unal_cnt), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
